// File: rtl/metronome_arm_sequencer.sv
// Metronome arm sequencer: ping-pong sweeps a synchronous arm ROM, one frame
// per period, and presents each fetched frame with a valid pulse plus a beat
// pulse on every sweep reversal.
module metronome_arm_sequencer #(
    parameter int unsigned DATA_WIDTH = 19,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [23:0]           period,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] arm_data,
    output logic                  arm_valid,
    output logic                  beat,
    output logic                  direction
);

    localparam int unsigned              PERIOD_WIDTH = 24;
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST    = '1;
    localparam logic [PERIOD_WIDTH-1:0]  CNT_ONE      = PERIOD_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic                    dir_q;
    logic [DATA_WIDTH-1:0]   arm_data_q;
    logic                    arm_valid_q;
    logic                    beat_q;
    logic [PERIOD_WIDTH-1:0] cnt_q;

    logic [PERIOD_WIDTH-1:0] cnt_load_d;
    logic [ADDR_WIDTH-1:0]   step_addr_d;
    logic                    step_dir_d;
    logic                    step_beat_d;

    assign rom_addr  = rom_addr_q;
    assign direction = dir_q;
    assign arm_data  = arm_data_q;
    assign arm_valid = arm_valid_q;
    assign beat      = beat_q;

    // Wait-counter reload value: a period of 0 behaves as 1.
    always_comb begin
        cnt_load_d = '0;
        if (period != '0) begin
            cnt_load_d = period - CNT_ONE;
        end
    end

    // Ping-pong step: endpoints turn around without wrapping and flag a beat.
    always_comb begin
        step_addr_d = rom_addr_q + ADDR_ONE;
        step_dir_d  = dir_q;
        step_beat_d = 1'b0;
        if (!dir_q) begin
            if (rom_addr_q == ADDR_LAST) begin
                step_addr_d = ADDR_LAST - ADDR_ONE;
                step_dir_d  = 1'b1;
                step_beat_d = 1'b1;
            end
        end else begin
            if (rom_addr_q == '0) begin
                step_addr_d = ADDR_ONE;
                step_dir_d  = 1'b0;
                step_beat_d = 1'b1;
            end else begin
                step_addr_d = rom_addr_q - ADDR_ONE;
            end
        end
    end

    // Sequencer FSM with registered outputs; restart overrides every state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            dir_q       <= 1'b0;
            arm_data_q  <= '0;
            arm_valid_q <= 1'b0;
            beat_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            arm_valid_q <= 1'b0;
            beat_q      <= 1'b0;
            if (restart) begin
                rom_addr_q <= '0;
                dir_q      <= 1'b0;
                state_q    <= FETCH1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (enable) begin
                            state_q <= FETCH1;
                        end
                    end
                    FETCH1: begin
                        state_q <= FETCH2;
                    end
                    FETCH2: begin
                        arm_data_q  <= rom_q;
                        arm_valid_q <= 1'b1;
                        cnt_q       <= cnt_load_d;
                        state_q     <= enable ? WAIT : IDLE;
                    end
                    WAIT: begin
                        if (!enable) begin
                            state_q <= IDLE;
                        end else if (cnt_q == '0) begin
                            rom_addr_q <= step_addr_d;
                            dir_q      <= step_dir_d;
                            beat_q     <= step_beat_d;
                            state_q    <= FETCH1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_metronome_arm_sequencer.sv
// Self-checking bench for metronome_arm_sequencer: ROM model rom[i]=i*3,
// scoreboard of expected frames popped on each arm_valid pulse.
module tb_metronome_arm_sequencer;

    localparam int unsigned DW = 19;
    localparam int unsigned AW = 7;

    logic          clk;
    logic          resetn;
    logic          enable;
    logic          restart;
    logic [23:0]   period;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] arm_data;
    logic          arm_valid;
    logic          beat;
    logic          direction;

    metronome_arm_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .restart   (restart),
        .period    (period),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .arm_data  (arm_data),
        .arm_valid (arm_valid),
        .beat      (beat),
        .direction (direction)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          dir;
        int            beats;  // beat pulses expected since the previous frame
        int            gap;    // negedges since previous valid / mark; 0 = unchecked
    } exp_t;

    typedef struct {
        logic [23:0] period;
        int          frames;
        int          gap;
    } vec_t;

    logic [DW-1:0] rom_mem [128];
    exp_t          sb_q[$];
    vec_t          vecs[6];
    int            tests      = 0;
    int            fails      = 0;
    int            cyc        = 0;
    int            mark       = 0;
    int            beats_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one edge after the address is sampled.
    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input int addr, input logic dir, input int beats, input int gap);
        exp_t e;
        e.data  = DW'(addr * 3);
        e.dir   = dir;
        e.beats = beats;
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    // Advance to the next falling edge and score any arm_valid pulse.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (beat) beats_seen++;
        if (arm_valid) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_arm_valid: got data %0d, required no pulse (t=%0t)", arm_data, $time);
            end else begin
                e = sb_q.pop_front();
                check("arm_data", 32'(arm_data), 32'(e.data));
                check("direction", 32'(direction), 32'(e.dir));
                check("beats_before_frame", 32'(beats_seen), 32'(e.beats));
                if (e.gap != 0) check("valid_spacing", 32'(cyc - mark), 32'(e.gap));
            end
            mark       = cyc;
            beats_seen = 0;
        end
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({name, "_direction"}, 32'(direction), 32'd0);
        check({name, "_arm_data"}, 32'(arm_data), 32'd0);
        check({name, "_arm_valid"}, 32'(arm_valid), 32'd0);
        check({name, "_beat"}, 32'(beat), 32'd0);
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        restart = 1'b0;
        resetn  = 1'b0;
        #1;
        check_zero_outputs("reset");
        tick();
        tick();
        resetn     = 1'b1;
        beats_seen = 0;
        sb_q.delete();
    endtask

    task automatic stop_and_idle();
        enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int p, pk, addr, bts;
        logic dir;

        for (int i = 0; i < 128; i++) rom_mem[i] = DW'(i * 3);
        resetn  = 1'b1;
        enable  = 1'b0;
        restart = 1'b0;
        period  = 24'd4;
        #2;

        // Basic run: period, frames, expected spacing (period_eff + 2).
        vecs[0] = '{24'd4,  8, 6};
        vecs[1] = '{24'd1,  6, 3};
        vecs[2] = '{24'd0,  6, 3};
        vecs[3] = '{24'd2,  5, 4};
        vecs[4] = '{24'd9,  3, 11};
        vecs[5] = '{24'd30, 2, 32};
        for (int v = 0; v < 6; v++) begin
            do_reset();
            period = vecs[v].period;
            for (int k = 0; k < vecs[v].frames; k++)
                push(k, 1'b0, 0, (k == 0) ? 3 : vecs[v].gap);
            mark   = cyc;
            enable = 1'b1;
            run_until_empty(vecs[v].frames * vecs[v].gap + 20, "table");
            stop_and_idle();
        end

        // Full sweep: triangle wave 0..127..0..., beat after each endpoint frame.
        do_reset();
        period = 24'd1;
        for (int k = 0; k < 300; k++) begin
            p    = k % 254;
            addr = (p <= 127) ? p : 254 - p;
            dir  = (p >= 128) || (p == 0 && k > 0);
            pk   = (k - 1) % 254;
            bts  = (k > 0 && (pk == 127 || (pk == 0 && k > 1))) ? 1 : 0;
            push(addr, dir, bts, 3);
        end
        mark   = cyc;
        enable = 1'b1;
        run_until_empty(1000, "sweep");
        stop_and_idle();

        // Pause during WAIT at address 40, resume 10 cycles later.
        do_reset();
        period = 24'd2;
        for (int k = 0; k <= 40; k++) push(k, 1'b0, 0, (k == 0) ? 3 : 4);
        mark   = cyc;
        enable = 1'b1;
        run_until_empty(300, "pause_pre");
        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pause_rom_addr", 32'(rom_addr), 32'd40);
        check("pause_direction", 32'(direction), 32'd0);
        push(40, 1'b0, 0, 3);
        push(41, 1'b0, 0, 4);
        push(42, 1'b0, 0, 4);
        mark   = cyc;
        enable = 1'b1;
        run_until_empty(40, "pause_resume");
        stop_and_idle();

        // Restart coincident with the reversal step from 127.
        do_reset();
        period = 24'd1;
        for (int k = 0; k <= 127; k++) push(k, 1'b0, 0, 3);
        mark   = cyc;
        enable = 1'b1;
        run_until_empty(500, "restart_pre");
        restart = 1'b1;
        push(0, 1'b0, 0, 3);
        push(1, 1'b0, 0, 3);
        mark = cyc;
        tick();
        restart = 1'b0;
        check("restart_rom_addr", 32'(rom_addr), 32'd0);
        check("restart_direction", 32'(direction), 32'd0);
        check("restart_beat", 32'(beat), 32'd0);
        run_until_empty(20, "restart_post");
        stop_and_idle();

        // Reset asserted during FETCH2 of address 9.
        do_reset();
        period = 24'd1;
        for (int k = 0; k <= 8; k++) push(k, 1'b0, 0, 3);
        mark   = cyc;
        enable = 1'b1;
        run_until_empty(100, "midreset_pre");
        tick();
        tick();
        check("fetch2_rom_addr", 32'(rom_addr), 32'd9);
        enable = 1'b0;
        resetn = 1'b0;
        #1;
        check_zero_outputs("midreset");
        for (int i = 0; i < 3; i++) tick();
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("post_reset_idle_rom_addr", 32'(rom_addr), 32'd0);
        check("post_reset_idle_arm_data", 32'(arm_data), 32'd0);
        push(0, 1'b0, 0, 3);
        mark   = cyc;
        enable = 1'b1;
        run_until_empty(20, "midreset_post");
        stop_and_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
